mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Parametrised multi-cycle multiply/divide unit; successor to the single-cycle ALU's mul/div hand-off.
- Sits in EX beside the single-cycle ALU. The ALU supplies the operation and signedness; this block iterates and produces the HI/LO results.
- Start/busy/done handshake; cancel input for exception flush. The pipeline stalls while busy.

Parameters:
WIDTH, 32, operand width; hi/lo are WIDTH bits each
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  in  1  clock, rising edge
resetn  in  1  synchronous active-low reset
start  in  1  request; sampled only in IDLE
op_div  in  1  0 = multiply, 1 = divide
op_sign  in  1  1 = signed operands (two's complement), 0 = unsigned
src_a  in  WIDTH  multiplicand / dividend
src_b  in  WIDTH  multiplier / divisor
cancel  in  1  abort current operation (exception flush)
busy  out  1  high from the cycle after start acceptance until done
done  out  1  one-cycle pulse; hi/lo valid from this cycle
hi  out  WIDTH  product upper half / remainder
lo  out  WIDTH  product lower half / quotient
div_by_zero  out  1  valid with done; 1 if divide with src_b == 0

Behaviour:
- Reset (resetn low at clk edge): state IDLE; busy = 0, done = 0, div_by_zero = 0, hi = 0, lo = 0, counter = 0. Reset mid-operation discards the operation with no done.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - start=1 and cancel=0 in cycle N: latch |src_a| and |src_b| (magnitudes if op_sign, raw otherwise), latch sign flags, counter = 0.
  - Transition to MUL or DIV per op_div.
- MUL: radix-2 shift-add, one bit per cycle, 2*WIDTH-bit accumulator, WIDTH cycles (N+1 .. N+WIDTH).
- DIV: restoring radix-2, one quotient bit per cycle, WIDTH cycles. Divisor 0 skips the arithmetic but still spends WIDTH cycles, so latency is fixed.
- FIX (cycle N+WIDTH+1), only when op_sign:
  - Product negated if sign_a ^ sign_b.
  - Quotient negated if sign_a ^ sign_b.
  - Remainder takes the dividend's sign.
- DONE (cycle N+WIDTH+2): hi/lo registered, done = 1 for exactly one cycle, busy = 0 in this cycle, return to IDLE. Total latency is WIDTH+2 cycles from start to done.
- busy = 1 in MUL, DIV and FIX only.
- hi/lo hold their last result until the next DONE; they never change mid-operation.
- Divide by zero: lo = all ones, hi = src_a as presented, div_by_zero = 1. div_by_zero clears on the next accepted start.
- Signed MIN / -1: lo = MIN, hi = 0; no overflow flag.
- start while not in IDLE: ignored. The pipeline holds start high until it sees done; the block re-accepts only from IDLE, and the cycle after DONE is IDLE.
- cancel:
  - In MUL, DIV or FIX: next state IDLE, no done, hi/lo/div_by_zero unchanged.
  - In IDLE with start: cancel wins; the operation is not accepted.
  - In DONE: done still pulses; results are committed.
- Width rules: all arithmetic is internal, 2*WIDTH+1 bits where needed. Negation is two's complement modulo 2^WIDTH per half, or 2^(2*WIDTH) for the product.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined: multiply uses a single combinational WIDTH x WIDTH signed/unsigned multiplier registered once. MUL lasts 1 cycle and FIX is skipped for multiply (sign handled in the multiplier). Multiply done arrives at N+2. Divide is unchanged.
- Undefined: multiply is iterative as above, with WIDTH+2 latency. Results are bit-identical in both builds.

Test Plan:
- Unsigned mul, WIDTH=32, 0xFFFFFFFF*0xFFFFFFFF, start at cycle 0 -> done at cycle 34 (cycle 2 with MDU_FAST_MUL_EN), hi=0xFFFFFFFE, lo=0x00000001, busy high cycles 1-33.
- Signed mul -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; signed div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; unsigned div 0xFFFFFFF9/2 -> lo=0x7FFFFFFC, hi=0x00000001.
- Div 5/0 (signed and unsigned) -> done at cycle 34, lo=0xFFFFFFFF, hi=0x00000005, div_by_zero=1. A following 6/3 gives div_by_zero=0, lo=2, hi=0.
- Signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- Divide started, cancel asserted at cycle 10 -> busy=0 at cycle 11, no done pulse ever, hi/lo keep prior values. cancel+start together in IDLE -> not accepted.
- resetn low at cycle 15 of a divide -> cycle 16 has busy=0, done=0, hi=lo=0. start held high during busy is ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle multiply/divide unit for the EX stage.
// The ALU supplies the operation (op_div) and signedness (op_sign). This
// block iterates one bit per cycle and returns HI/LO.
//
// Handshake: start is sampled only in IDLE, and is accepted when cancel is
// low in the same cycle. busy is high in MUL, DIV and FIX. done pulses for
// one cycle in DONE, and hi/lo/div_by_zero are valid from that cycle on.
// cancel in MUL/DIV/FIX drops the operation, and no result is committed.
//
// Optional build macro MDU_FAST_MUL_EN: multiply uses one registered
// combinational multiplier (done at N+2) instead of shift-add (done at
// N+WIDTH+2). Divide is the same in both builds, and so are the results.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             op_div,
  input  logic             op_sign,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Operation context latched at acceptance
  logic             sign_q;       // signed operation
  logic             div_q;        // divide (vs multiply)
  logic             sign_a_q;
  logic             sign_b_q;
  logic             b_zero_q;
  logic [WIDTH-1:0] raw_a_q;      // dividend as presented, for divide-by-zero
  logic [WIDTH-1:0] mag_b_q;      // |src_b| or raw src_b
  logic [CNT_W-1:0] cnt_q;

  // Working accumulator: {acc_hi_q, acc_lo_q}
  // multiply: partial product upper half / multiplier shifting out
  // divide:   partial remainder / dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;

  // Committed results
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             dbz_q;

`ifdef MDU_FAST_MUL_EN
  logic [WIDTH-1:0]   raw_b_q;
  logic [2*WIDTH-1:0] fast_a;
  logic [2*WIDTH-1:0] fast_b;
  logic [2*WIDTH-1:0] fast_prod;
`else
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_fix;
`endif

  logic             accept;
  logic             last_iter;
  logic             commit;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign accept    = (state == S_IDLE) && start && !cancel;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  assign busy        = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
  assign done        = (state == S_DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

  // Operand magnitudes: unsigned ops pass operands through unchanged
  always_comb begin
    mag_a = src_a;
    mag_b = src_b;
    if (op_sign && src_a[WIDTH-1]) mag_a = -src_a;
    if (op_sign && src_b[WIDTH-1]) mag_b = -src_b;
  end

  // One restoring-division step: shift in the next dividend bit, trial-subtract
  always_comb begin
    rem_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, mag_b_q};
  end

`ifdef MDU_FAST_MUL_EN
  // Single multiplier on sign-extended operands; the low 2*WIDTH bits are
  // the correct product for both signed and unsigned operands
  always_comb begin
    fast_a    = {{WIDTH{sign_q & raw_a_q[WIDTH-1]}}, raw_a_q};
    fast_b    = {{WIDTH{sign_q & raw_b_q[WIDTH-1]}}, raw_b_q};
    fast_prod = fast_a * fast_b;
  end
`else
  // One shift-add step, plus the signed correction of the finished product
  always_comb begin
    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_b_q} : '0);
    prod_mag = {acc_hi_q, acc_lo_q};
    prod_fix = prod_mag;
    if (sign_q && (sign_a_q ^ sign_b_q)) prod_fix = -prod_mag;
  end
`endif

  // Final result selection (this value is committed on entry to DONE)
  always_comb begin
    res_hi = acc_hi_q;
    res_lo = acc_lo_q;
    if (div_q) begin
      if (b_zero_q) begin
        res_hi = raw_a_q;
        res_lo = '1;
      end else begin
        if (sign_q && (sign_a_q ^ sign_b_q)) res_lo = -acc_lo_q;
        if (sign_q && sign_a_q)              res_hi = -acc_hi_q;
      end
    end else begin
`ifdef MDU_FAST_MUL_EN
      res_hi = fast_prod[2*WIDTH-1:WIDTH];
      res_lo = fast_prod[WIDTH-1:0];
`else
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
`endif
    end
  end

  // Results commit only on a non-cancelled entry into DONE
  always_comb begin
    commit = (state == S_FIX) && !cancel;
`ifdef MDU_FAST_MUL_EN
    if ((state == S_MUL) && !cancel) commit = 1'b1;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = op_div ? S_DIV : S_MUL;
      end
      S_MUL: begin
`ifdef MDU_FAST_MUL_EN
        if (cancel) state_nxt = S_IDLE;
        else        state_nxt = S_DONE;
`else
        if (cancel)         state_nxt = S_IDLE;
        else if (last_iter) state_nxt = S_FIX;
`endif
      end
      S_DIV: begin
        if (cancel)         state_nxt = S_IDLE;
        else if (last_iter) state_nxt = S_FIX;
      end
      S_FIX: begin
        if (cancel) state_nxt = S_IDLE;
        else        state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch on accept, iterate in MUL/DIV, commit results on entry to DONE
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sign_q   <= 1'b0;
      div_q    <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      raw_a_q  <= '0;
      mag_b_q  <= '0;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
`ifdef MDU_FAST_MUL_EN
      raw_b_q  <= '0;
`endif
    end else begin
      if (accept) begin
        sign_q   <= op_sign;
        div_q    <= op_div;
        sign_a_q <= op_sign & src_a[WIDTH-1];
        sign_b_q <= op_sign & src_b[WIDTH-1];
        b_zero_q <= (src_b == '0);
        raw_a_q  <= src_a;
        mag_b_q  <= mag_b;
        cnt_q    <= '0;
        acc_hi_q <= '0;
        acc_lo_q <= mag_a;
        dbz_q    <= 1'b0;
`ifdef MDU_FAST_MUL_EN
        raw_b_q  <= src_b;
`endif
      end else if (state == S_DIV) begin
        cnt_q <= cnt_q + 1'b1;
        // A zero divisor skips the arithmetic; latency stays fixed
        if (!b_zero_q) begin
          if (!rem_diff[WIDTH]) begin
            acc_hi_q <= rem_diff[WIDTH-1:0];
            acc_lo_q <= {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_q <= rem_sh[WIDTH-1:0];
            acc_lo_q <= {acc_lo_q[WIDTH-2:0], 1'b0};
          end
        end
      end
`ifndef MDU_FAST_MUL_EN
      else if (state == S_MUL) begin
        cnt_q    <= cnt_q + 1'b1;
        acc_hi_q <= mul_sum[WIDTH:1];
        acc_lo_q <= {mul_sum[0], acc_lo_q[WIDTH-1:1]};
      end
`endif
      if (commit) begin
        hi_q  <= res_hi;
        lo_q  <= res_lo;
        dbz_q <= div_q & b_zero_q;
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed vectors for mdu_iter (WIDTH=32) with hand-computed
// results, latency, busy profile, cancel and mid-operation reset.
module tb_mdu_iter;

  localparam int W       = 32;
  localparam int DIV_LAT = W + 2;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = W + 2;
`endif

  logic         clk;
  logic         resetn;
  logic         start;
  logic         op_div;
  logic         op_sign;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         cancel;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;

  // Expected committed results (what hi/lo must hold between operations)
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  mdu_iter #(.WIDTH(W), .CNT_W(6)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .op_div      (op_div),
    .op_sign     (op_sign),
    .src_a       (src_a),
    .src_b       (src_b),
    .cancel      (cancel),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One operation with start held high until done, as the pipeline does.
  // Cycle 0 is the accepting cycle; outputs are sampled on the falling edge.
  task automatic run_op(input string tag, input logic d, input logic s,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                        input logic e_dbz, input int e_lat);
    int busy_cnt;
    int lat;
    @(negedge clk);
    op_div = d; op_sign = s; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk);
    busy_cnt = 0;
    lat = 0;
    for (int k = 1; k <= 100 && lat == 0; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (k == e_lat - 1) begin
        check({tag, " hold_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " hold_lo"}, 64'(lo), 64'(exp_lo));
      end
      if (done) begin
        lat = k;
        check({tag, " hi"}, 64'(hi), 64'(e_hi));
        check({tag, " lo"}, 64'(lo), 64'(e_lo));
        check({tag, " dbz"}, 64'(div_by_zero), 64'(e_dbz));
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(e_lat));
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(e_lat - 1));
    @(negedge clk);
    start = 1'b0;
    check({tag, " no_reaccept"}, 64'(busy), 64'd0);
    exp_hi = e_hi;
    exp_lo = e_lo;
  endtask

  int done_cnt;

  initial begin
    resetn = 1'b0; start = 1'b0; op_div = 1'b0; op_sign = 1'b0;
    src_a = '0; src_b = '0; cancel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    check("rst dbz", 64'(div_by_zero), 64'd0);
    resetn = 1'b1;

    // Multiply
    run_op("umul_max", 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, MUL_LAT);
    run_op("smul_m3x5", 0, 1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, MUL_LAT);
    run_op("smul_min2", 0, 1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, MUL_LAT);
    run_op("umul_min2", 0, 0, 32'h80000000, 32'h00000003, 32'h00000001, 32'h80000000, 0, MUL_LAT);

    // Divide
    run_op("sdiv_m7_2", 1, 1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, DIV_LAT);
    run_op("udiv_big_2", 1, 0, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 0, DIV_LAT);
    run_op("sdiv_7_m2", 1, 1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, DIV_LAT);
    run_op("sdiv_5_0", 1, 1, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1, DIV_LAT);
    run_op("udiv_5_0", 1, 0, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1, DIV_LAT);
    run_op("sdiv_m5_0", 1, 1, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1, DIV_LAT);
    run_op("udiv_6_3", 1, 0, 32'h00000006, 32'h00000003, 32'h00000000, 32'h00000002, 0, DIV_LAT);
    run_op("sdiv_min_m1", 1, 1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, DIV_LAT);
    run_op("udiv_100_7", 1, 0, 32'd100, 32'd7, 32'd2, 32'd14, 0, DIV_LAT);

    // Cancel at cycle 10 of a divide: no done, results unchanged
    @(negedge clk);
    op_div = 1'b1; op_sign = 1'b0; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) @(negedge clk);
    start = 1'b0; cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel busy", 64'(busy), 64'd0);
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("cancel no_done", 64'(done_cnt), 64'd0);
    check("cancel hi", 64'(hi), 64'(exp_hi));
    check("cancel lo", 64'(lo), 64'(exp_lo));

    // cancel with start in IDLE: not accepted
    @(negedge clk);
    op_div = 1'b0; src_a = 32'd9; src_b = 32'd9; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("idle_cancel busy", 64'(busy), 64'd0);
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("idle_cancel no_done", 64'(done_cnt), 64'd0);
    check("idle_cancel lo", 64'(lo), 64'(exp_lo));

    // Reset at cycle 15 of a divide
    @(negedge clk);
    op_div = 1'b1; op_sign = 1'b1; src_a = 32'hFFFFFF00; src_b = 32'd5; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 15; k++) @(negedge clk);
    start = 1'b0; resetn = 1'b0;
    @(negedge clk);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst hi", 64'(hi), 64'd0);
    check("midrst lo", 64'(lo), 64'd0);
    resetn = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midrst no_done", 64'(done_cnt), 64'd0);

    // Normal operation after reset
    run_op("post_rst_umul", 0, 0, 32'd12345, 32'd1000, 32'd0, 32'd12345000, 0, MUL_LAT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
